// File: rtl/sum_result_buffer.sv
// Result FIFO behind the pipelined adder: captures {cout, sum}, serves it FWFT over
// valid/ready, and returns issue credits so the adder output can never overrun storage.
module sum_result_buffer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned LATENCY = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue,
    output logic                       issue_ok,
    input  logic                       v_in,
    input  logic [WIDTH-1:0]           sum_in,
    input  logic                       cout_in,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_sum,
    output logic                       m_cout,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       err
);

    localparam int unsigned LVL_W   = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned FLUSH_W = $clog2(LATENCY + 1);
    localparam int unsigned SUM_W   = LVL_W + 1;

    logic [WIDTH:0]     mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [LVL_W-1:0]   inflight, inflight_nxt, level_nxt;
    logic [FLUSH_W-1:0] flush_cnt, flush_nxt;
    logic               err_nxt;
    logic               flushing, pop, push_req, push, full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake and credit status, derived from registered state only
    always_comb begin
        flushing = (flush_cnt != '0);
        full     = (level == LVL_W'(DEPTH));
        m_valid  = (level != '0);
        pop      = m_valid && m_ready;
        push_req = v_in && !flushing;
        push     = push_req && (!full || pop);
        issue_ok = !flushing && ((SUM_W'(level) + SUM_W'(inflight)) < SUM_W'(DEPTH));
        {m_cout, m_sum} = mem[rd_ptr];
    end

    // Next-state: pointers, occupancy, credits, sticky error, flush countdown
    always_comb begin
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        level_nxt    = level;
        inflight_nxt = inflight;
        err_nxt      = err;
        flush_nxt    = flush_cnt;

        if (flushing) flush_nxt = flush_cnt - FLUSH_W'(1);
        if (push)     wr_ptr_nxt = ptr_inc(wr_ptr);
        if (pop)      rd_ptr_nxt = ptr_inc(rd_ptr);

        if (push && !pop)      level_nxt = level + LVL_W'(1);
        else if (pop && !push) level_nxt = level - LVL_W'(1);

        // Stale adder results and issues during flush are ignored entirely
        if (!flushing) begin
            if (issue && !v_in) begin
                if (inflight != LVL_W'(DEPTH)) inflight_nxt = inflight + LVL_W'(1);
            end else if (v_in && !issue && inflight != '0) begin
                inflight_nxt = inflight - LVL_W'(1);
            end
            if (push_req && full && !pop) err_nxt = 1'b1;
            if (issue && !issue_ok)       err_nxt = 1'b1;
            if (v_in && inflight == '0)   err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            inflight  <= '0;
            err       <= 1'b0;
            flush_cnt <= FLUSH_W'(LATENCY);
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            level     <= level_nxt;
            inflight  <= inflight_nxt;
            err       <= err_nxt;
            flush_cnt <= flush_nxt;
        end
    end

    // Storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cout_in, sum_in};
    end

endmodule

// File: tb/tb_sum_result_buffer.sv
// Directed bench for sum_result_buffer: a reference model and scoreboard track every
// cycle of the DEPTH=8 instance; a DEPTH=5 instance covers pointer wrap and async reset.
`timescale 1ns/1ps
module tb_sum_result_buffer;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned LATENCY = 4;
    localparam int unsigned DEPTH5  = 5;
    localparam int unsigned DW      = WIDTH + 1;
    localparam int unsigned LVL_W   = $clog2(DEPTH + 1);
    localparam int unsigned LVL5_W  = $clog2(DEPTH5 + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              issue, issue_ok, v_in, cout_in, m_valid, m_ready, m_cout, err;
    logic [WIDTH-1:0]  sum_in, m_sum;
    logic [LVL_W-1:0]  level;

    logic              issue5, issue_ok5, v_in5, cout_in5, m_valid5, m_ready5, m_cout5, err5;
    logic [WIDTH-1:0]  sum_in5, m_sum5;
    logic [LVL5_W-1:0] level5;

    sum_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst), .issue(issue), .issue_ok(issue_ok),
        .v_in(v_in), .sum_in(sum_in), .cout_in(cout_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum), .m_cout(m_cout),
        .level(level), .err(err)
    );

    sum_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH5), .LATENCY(LATENCY)) dut5 (
        .clk(clk), .rst(rst), .issue(issue5), .issue_ok(issue_ok5),
        .v_in(v_in5), .sum_in(sum_in5), .cout_in(cout_in5),
        .m_valid(m_valid5), .m_ready(m_ready5), .m_sum(m_sum5), .m_cout(m_cout5),
        .level(level5), .err(err5)
    );

    int checks = 0;
    int errors = 0;

    logic [WIDTH:0]  sb[$];
    logic [WIDTH:0]  sb5[$];
    logic [WIDTH+1:0] pipe[$];
    logic            use_adder;
    logic [WIDTH:0]  op_data;

    int   ml, mi, mf, pops, ml5, issued;
    logic me;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ml = 0; mi = 0; mf = int'(LATENCY); me = 1'b0; pops = 0;
        sb.delete();
    endtask

    // One cycle of the DEPTH=8 instance: compare against the model, then advance both
    task automatic tick();
        logic           flush_m, ok_m, pop_m, push_m;
        logic [WIDTH:0] exp_d;
        logic [WIDTH+1:0] p;
        flush_m = (mf != 0);
        ok_m    = !flush_m && (ml + mi < int'(DEPTH));
        chk("m_valid",  64'(m_valid),  64'(ml != 0));
        chk("level",    64'(level),    64'(ml));
        chk("issue_ok", 64'(issue_ok), 64'(ok_m));
        chk("err",      64'(err),      64'(me));
        pop_m  = (ml != 0) && m_ready;
        push_m = v_in && !flush_m && (ml != int'(DEPTH) || pop_m);
        if (pop_m) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'(1));
            end else begin
                exp_d = sb.pop_front();
                chk("head", 64'({m_cout, m_sum}), 64'(exp_d));
                pops++;
            end
        end
        if (push_m) sb.push_back({cout_in, sum_in});
        if (!flush_m) begin
            if (v_in && ml == int'(DEPTH) && !pop_m) me = 1'b1;
            if (issue && !ok_m)                     me = 1'b1;
            if (v_in && mi == 0)                    me = 1'b1;
            if (issue && !v_in) begin
                if (mi != int'(DEPTH)) mi++;
            end else if (v_in && !issue && mi != 0) begin
                mi--;
            end
        end
        if (push_m && !pop_m)      ml++;
        else if (pop_m && !push_m) ml--;
        if (flush_m) mf--;
        pipe.push_back({issue, op_data});
        @(posedge clk); #1;
        // Adder stand-in: the op issued LATENCY cycles ago returns now
        if (pipe.size() == int'(LATENCY)) begin
            p = pipe.pop_front();
            if (use_adder) begin
                v_in    = p[WIDTH+1];
                cout_in = p[WIDTH];
                sum_in  = p[WIDTH-1:0];
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        issue = 0; v_in = 0; sum_in = '0; cout_in = 0; m_ready = 0;
        issue5 = 0; v_in5 = 0; sum_in5 = '0; cout_in5 = 0; m_ready5 = 0;
        use_adder = 0; op_data = '0; issued = 0; ml5 = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid",  64'(m_valid),  64'(0));
        chk("rst_issue_ok", 64'(issue_ok), 64'(0));
        chk("rst_level",    64'(level),    64'(0));
        chk("rst_err",      64'(err),      64'(0));
        chk("rst_issue_ok5", 64'(issue_ok5), 64'(0));
        rst = 1'b0;

        // Flush: stale adder output is discarded for LATENCY cycles
        v_in = 1; sum_in = 32'hDEAD_BEEF; cout_in = 0;
        repeat (LATENCY) begin
            chk("flush_issue_ok", 64'(issue_ok), 64'(0));
            tick();
        end
        v_in = 0;
        chk("flush_level",   64'(level),    64'(0));
        chk("flush_done_ok", 64'(issue_ok), 64'(1));
        chk("flush_err",     64'(err),      64'(0));
        tick();

        // Three ops through the adder with a ready consumer
        use_adder = 1; m_ready = 1;
        issue = 1; op_data = {1'b0, 32'd5}; tick();
        op_data = {1'b1, 32'd7}; tick();
        op_data = {1'b0, 32'd9}; tick();
        issue = 0; op_data = '0;
        repeat (8) tick();
        chk("t2_pops",  64'(pops),      64'(3));
        chk("t2_level", 64'(level),     64'(0));
        chk("t2_sb",    64'(sb.size()), 64'(0));

        // Issue whenever credit allows with a stalled consumer
        m_ready = 0;
        repeat (20) begin
            issue   = issue_ok;
            op_data = DW'(100 + issued);
            if (issue) issued++;
            tick();
        end
        issue = 0; op_data = '0;
        chk("t3_issues",   64'(issued),   64'(DEPTH));
        chk("t3_level",    64'(level),    64'(DEPTH));
        chk("t3_issue_ok", 64'(issue_ok), 64'(0));
        chk("t3_err",      64'(err),      64'(0));

        // Full with simultaneous pop and push: slot reused, 0x11 queued last.
        // No credit is outstanding, so the forced result also flags err.
        use_adder = 0;
        v_in = 1; sum_in = 32'h11; cout_in = 0; m_ready = 1;
        tick();
        v_in = 0; m_ready = 0;
        chk("t4_level", 64'(level), 64'(DEPTH));
        tick();

        // Full, stalled consumer: the forced result is dropped
        v_in = 1; sum_in = 32'h22; cout_in = 1;
        tick();
        v_in = 0;
        repeat (3) tick();
        chk("t5_level", 64'(level), 64'(DEPTH));
        chk("t5_err",   64'(err),   64'(1));
        m_ready = 1;
        repeat (10) tick();
        chk("t5_drain_sb",    64'(sb.size()), 64'(0));
        chk("t5_drain_level", 64'(level),     64'(0));
        chk("t5_err_sticky",  64'(err),       64'(1));

        // DEPTH=5: 20 results streamed through, wrapping the pointers four times
        for (int k = 0; k < 26; k++) begin
            logic pop5;
            logic [WIDTH:0] exp5;
            v_in5    = (k < 20);
            sum_in5  = WIDTH'(k);
            cout_in5 = k[0];
            m_ready5 = (k >= 3);
            #1;
            chk("d5_level", 64'(level5),   64'(ml5));
            chk("d5_valid", 64'(m_valid5), 64'(ml5 != 0));
            pop5 = (ml5 != 0) && m_ready5;
            if (pop5) begin
                if (sb5.size() == 0) begin
                    chk("d5_underflow", 64'(sb5.size()), 64'(1));
                end else begin
                    exp5 = sb5.pop_front();
                    chk("d5_head", 64'({m_cout5, m_sum5}), 64'(exp5));
                end
            end
            if (v_in5) sb5.push_back({cout_in5, sum_in5});
            if (v_in5 && !pop5)      ml5++;
            else if (pop5 && !v_in5) ml5--;
            @(posedge clk); #1;
        end
        chk("d5_sb", 64'(sb5.size()), 64'(0));

        // Reset mid-stream clears both instances without waiting for a clock edge
        m_ready = 0; m_ready5 = 0;
        for (int k = 0; k < 3; k++) begin
            v_in  = 1; sum_in  = WIDTH'(200 + k);
            v_in5 = 1; sum_in5 = WIDTH'(50 + k);
            @(posedge clk); #1;
        end
        v_in = 0; v_in5 = 0;
        chk("pre_rst_level",  64'(level),  64'(3));
        chk("pre_rst_level5", 64'(level5), 64'(3));
        #2;
        rst = 1'b1;
        #1;
        chk("async_m_valid5", 64'(m_valid5), 64'(0));
        chk("async_level5",   64'(level5),   64'(0));
        chk("async_m_valid",  64'(m_valid),  64'(0));
        chk("async_level",    64'(level),    64'(0));
        chk("async_issue_ok", 64'(issue_ok), 64'(0));
        chk("async_err",      64'(err),      64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        repeat (LATENCY) begin
            chk("reflush_issue_ok", 64'(issue_ok), 64'(0));
            tick();
        end
        chk("post_rst_issue_ok", 64'(issue_ok), 64'(1));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
